// File: rtl/draw_screen_manager_pkg.sv
// Shared screen encodings and colour constants for the background renderer.
// The MENU/GAME/PAUSE/OVER encoding is what the mode output reports.
package draw_screen_manager_pkg;

    typedef enum logic [1:0] {
        MENU  = 2'd0,
        GAME  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } screen_t;

    localparam logic [11:0] COL_BLACK  = 12'h000;
    localparam logic [11:0] COL_YELLOW = 12'hff0;
    localparam logic [11:0] COL_RED    = 12'hf00;
    localparam logic [11:0] COL_GREEN  = 12'h0f0;
    localparam logic [11:0] COL_BLUE   = 12'h00f;
    localparam logic [11:0] COL_WHITE  = 12'hfff;
    localparam logic [11:0] COL_GREY   = 12'h888;
    localparam logic [11:0] COL_DIM    = 12'h222;

    // On OVER the ring flashes red/white; the other play screens use a fixed colour.
    function automatic logic [11:0] border_colour(input screen_t screen, input logic flash);
        logic [11:0] colour;
        colour = COL_WHITE;
        case (screen)
            PAUSE:   colour = COL_GREY;
            OVER:    colour = flash ? COL_RED : COL_WHITE;
            default: colour = COL_WHITE;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/draw_screen_manager_rect_hit.sv
// Combinational point-in-rectangle test over the half-open box [X0,X1) x [Y0,Y1).
module draw_screen_manager_rect_hit #(
    parameter logic [11:0] X0 = 12'd1,
    parameter logic [11:0] X1 = 12'd2,
    parameter logic [11:0] Y0 = 12'd1,
    parameter logic [11:0] Y1 = 12'd2
) (
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    output logic        o_hit
);

    assign o_hit = (i_x >= X0) && (i_x < X1) && (i_y >= Y0) && (i_y < Y1);

endmodule

// File: rtl/draw_screen_manager.sv
// Screen FSM plus a 2-stage VGA pipeline that paints the menu / arena background.
// Stage 1 registers hit flags, stage 2 registers the final colour and delayed timing.
module draw_screen_manager
    import draw_screen_manager_pkg::*;
#(
    parameter int TOP_V_LINE    = 367,
    parameter int BOTTOM_V_LINE = 667,
    parameter int LEFT_H_LINE   = 361,
    parameter int RIGHT_H_LINE  = 661,
    parameter int BORDER        = 10,
    parameter int BTN_X0        = 400,
    parameter int BTN_X1        = 690,
    parameter int BTN_Y0        = 400,
    parameter int BTN_Y1        = 480,
    parameter int FLASH_FRAMES  = 16,
    parameter int H_LAST        = 1023,
    parameter int V_LAST        = 767
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    input  logic        game_on,
    input  logic        menu_on,
    input  logic        pause_tgl,
    input  logic        game_over,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [1:0]  mode,
    output logic        hover
);

    localparam logic [11:0] ARENA_X0 = 12'(LEFT_H_LINE);
    localparam logic [11:0] ARENA_X1 = 12'(RIGHT_H_LINE);
    localparam logic [11:0] ARENA_Y0 = 12'(TOP_V_LINE);
    localparam logic [11:0] ARENA_Y1 = 12'(BOTTOM_V_LINE);
    localparam logic [11:0] RING_X0  = 12'(LEFT_H_LINE - BORDER);
    localparam logic [11:0] RING_X1  = 12'(RIGHT_H_LINE + BORDER);
    localparam logic [11:0] RING_Y0  = 12'(TOP_V_LINE - BORDER);
    localparam logic [11:0] RING_Y1  = 12'(BOTTOM_V_LINE + BORDER);
    localparam logic [11:0] B_X0     = 12'(BTN_X0);
    localparam logic [11:0] B_X1     = 12'(BTN_X1);
    localparam logic [11:0] B_Y0     = 12'(BTN_Y0);
    localparam logic [11:0] B_Y1     = 12'(BTN_Y1);
    localparam logic [11:0] H_END    = 12'(H_LAST);
    localparam logic [11:0] V_END    = 12'(V_LAST);
    localparam int          CW       = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FLASH_FRAMES - 1);

    logic w_btnPix, w_btnMouse, w_arena;
    logic w_barTop, w_barBot, w_barLeft, w_barRight, w_ring;
    logic w_click, w_vblnkRise, w_enterOver, w_blank;
    logic [11:0] w_colour;

    screen_t r_state, r_shown, r_s1Screen;
    logic [1:0] r_mode;
    logic r_hover, r_mouseLeftD, r_vblnkD, r_flash;
    logic [CW-1:0] r_frameCnt;

    logic [11:0] r_s1Hcount, r_s1Vcount;
    logic r_s1Hsync, r_s1Vsync, r_s1Hblnk, r_s1Vblnk;
    logic r_s1Blank, r_s1VTop, r_s1VBot, r_s1HLeft, r_s1HRight;
    logic r_s1Btn, r_s1Ring, r_s1Arena, r_s1Flash, r_s1Hover;

    draw_screen_manager_rect_hit #(.X0(B_X0), .X1(B_X1), .Y0(B_Y0), .Y1(B_Y1))
        u_btnMouse (.i_x(xpos), .i_y(ypos), .o_hit(w_btnMouse));
    draw_screen_manager_rect_hit #(.X0(B_X0), .X1(B_X1), .Y0(B_Y0), .Y1(B_Y1))
        u_btnPix (.i_x(hcount_in), .i_y(vcount_in), .o_hit(w_btnPix));
    draw_screen_manager_rect_hit #(.X0(ARENA_X0), .X1(ARENA_X1), .Y0(ARENA_Y0), .Y1(ARENA_Y1))
        u_arena (.i_x(hcount_in), .i_y(vcount_in), .o_hit(w_arena));
    draw_screen_manager_rect_hit #(.X0(RING_X0), .X1(RING_X1), .Y0(RING_Y0), .Y1(ARENA_Y0))
        u_barTop (.i_x(hcount_in), .i_y(vcount_in), .o_hit(w_barTop));
    draw_screen_manager_rect_hit #(.X0(RING_X0), .X1(RING_X1), .Y0(ARENA_Y1), .Y1(RING_Y1))
        u_barBot (.i_x(hcount_in), .i_y(vcount_in), .o_hit(w_barBot));
    draw_screen_manager_rect_hit #(.X0(RING_X0), .X1(ARENA_X0), .Y0(RING_Y0), .Y1(RING_Y1))
        u_barLeft (.i_x(hcount_in), .i_y(vcount_in), .o_hit(w_barLeft));
    draw_screen_manager_rect_hit #(.X0(ARENA_X1), .X1(RING_X1), .Y0(RING_Y0), .Y1(RING_Y1))
        u_barRight (.i_x(hcount_in), .i_y(vcount_in), .o_hit(w_barRight));

    assign w_ring      = w_barTop | w_barBot | w_barLeft | w_barRight;
    assign w_blank     = hblnk_in | vblnk_in;
    assign w_click     = mouse_left & ~r_mouseLeftD;
    assign w_vblnkRise = vblnk_in & ~r_vblnkD;
    assign w_enterOver = ~menu_on & (r_state == GAME) & game_over;
    assign mode        = r_mode;
    assign hover       = r_hover;

    // Screen FSM; menu_on overrides everything, game_over beats pause_tgl in GAME.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MENU;
            r_mode  <= 2'd0;
            r_hover <= 1'b0;
        end else begin
            r_mode  <= r_state;
            r_hover <= w_btnMouse & (r_state == MENU);
            if (menu_on) begin
                r_state <= MENU;
            end else begin
                case (r_state)
                    MENU:  if ((w_btnMouse & w_click) | game_on) r_state <= GAME;
                    GAME:  if (game_over) r_state <= OVER;
                           else if (pause_tgl) r_state <= PAUSE;
                    PAUSE: if (pause_tgl) r_state <= GAME;
                    OVER:  if (w_click) r_state <= MENU;
                    default: r_state <= MENU;
                endcase
            end
        end
    end

    // The displayed screen and the flash phase only advance at frame start.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_mouseLeftD <= 1'b0;
            r_vblnkD     <= 1'b0;
            r_shown      <= MENU;
            r_frameCnt   <= '0;
            r_flash      <= 1'b0;
        end else begin
            r_mouseLeftD <= mouse_left;
            r_vblnkD     <= vblnk_in;
            if (w_vblnkRise) r_shown <= r_state;
            if (w_enterOver) begin
                r_frameCnt <= '0;
                r_flash    <= 1'b0;
            end else if (w_vblnkRise) begin
                if (r_frameCnt == CNT_LAST) begin
                    r_frameCnt <= '0;
                    r_flash    <= ~r_flash;
                end else begin
                    r_frameCnt <= r_frameCnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Hcount <= '0;    r_s1Vcount <= '0;
            r_s1Hsync  <= 1'b0;  r_s1Vsync  <= 1'b0;
            r_s1Hblnk  <= 1'b0;  r_s1Vblnk  <= 1'b0;
            r_s1Blank  <= 1'b0;  r_s1VTop   <= 1'b0;
            r_s1VBot   <= 1'b0;  r_s1HLeft  <= 1'b0;
            r_s1HRight <= 1'b0;  r_s1Btn    <= 1'b0;
            r_s1Ring   <= 1'b0;  r_s1Arena  <= 1'b0;
            r_s1Flash  <= 1'b0;  r_s1Hover  <= 1'b0;
            r_s1Screen <= MENU;
        end else begin
            r_s1Hcount <= hcount_in;            r_s1Vcount <= vcount_in;
            r_s1Hsync  <= hsync_in;             r_s1Vsync  <= vsync_in;
            r_s1Hblnk  <= hblnk_in;             r_s1Vblnk  <= vblnk_in;
            r_s1Blank  <= w_blank;              r_s1VTop   <= (vcount_in == 12'd0);
            r_s1VBot   <= (vcount_in == V_END); r_s1HLeft  <= (hcount_in == 12'd0);
            r_s1HRight <= (hcount_in == H_END); r_s1Btn    <= w_btnPix;
            r_s1Ring   <= w_ring;               r_s1Arena  <= w_arena;
            r_s1Flash  <= r_flash;              r_s1Hover  <= r_hover;
            r_s1Screen <= r_shown;
        end
    end

    always_comb begin
        w_colour = COL_BLACK;
        if (r_s1Blank)       w_colour = COL_BLACK;
        else if (r_s1VTop)   w_colour = COL_YELLOW;
        else if (r_s1VBot)   w_colour = COL_RED;
        else if (r_s1HLeft)  w_colour = COL_GREEN;
        else if (r_s1HRight) w_colour = COL_BLUE;
        else if (r_s1Screen == MENU) begin
            if (r_s1Btn) w_colour = r_s1Hover ? COL_GREEN : COL_WHITE;
        end else if (r_s1Ring) begin
            w_colour = border_colour(r_s1Screen, r_s1Flash);
        end else if ((r_s1Screen == PAUSE) && r_s1Arena) begin
            w_colour = COL_DIM;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;   vcount_out <= '0;
            hsync_out  <= 1'b0; vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0; vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= r_s1Hcount; vcount_out <= r_s1Vcount;
            hsync_out  <= r_s1Hsync;  vsync_out  <= r_s1Vsync;
            hblnk_out  <= r_s1Hblnk;  vblnk_out  <= r_s1Vblnk;
            rgb_out    <= w_colour;
        end
    end

endmodule

// File: tb/tb_draw_screen_manager.sv
// Scoreboard bench for draw_screen_manager: screen FSM, frame-start commit, flash and pipeline timing.
module tb_draw_screen_manager;

    localparam int FLASH = 2;

    logic        pclk = 1'b0;
    logic        rstN;
    logic [11:0] hcountIn, vcountIn, xposIn, yposIn;
    logic        hsyncIn, vsyncIn, hblnkIn, vblnkIn;
    logic        mouseLeft, gameOn, menuOn, pauseTgl, gameOver;
    logic [11:0] hcountOut, vcountOut, rgbOut;
    logic        hsyncOut, vsyncOut, hblnkOut, vblnkOut, hoverOut;
    logic [1:0]  modeOut;

    typedef struct packed {
        logic [11:0] h;
        logic [11:0] v;
        logic [3:0]  strobes;
        logic [11:0] rgb;
    } exp_t;

    exp_t expQ[$];
    int   vecCount  = 0;
    int   missCount = 0;

    logic [1:0] mState, mShown;
    logic       mFlash, mHover, mPrevVblnk;
    int         mCnt;

    draw_screen_manager #(.FLASH_FRAMES(FLASH)) dut (
        .pclk(pclk), .rst_n(rstN),
        .hcount_in(hcountIn), .vcount_in(vcountIn),
        .hsync_in(hsyncIn), .vsync_in(vsyncIn), .hblnk_in(hblnkIn), .vblnk_in(vblnkIn),
        .xpos(xposIn), .ypos(yposIn), .mouse_left(mouseLeft),
        .game_on(gameOn), .menu_on(menuOn), .pause_tgl(pauseTgl), .game_over(gameOver),
        .hcount_out(hcountOut), .vcount_out(vcountOut),
        .hsync_out(hsyncOut), .vsync_out(vsyncOut), .hblnk_out(hblnkOut), .vblnk_out(vblnkOut),
        .rgb_out(rgbOut), .mode(modeOut), .hover(hoverOut)
    );

    always #5 pclk = ~pclk;

    function automatic logic inButton(input logic [11:0] x, input logic [11:0] y);
        return (x >= 12'd400) && (x < 12'd690) && (y >= 12'd400) && (y < 12'd480);
    endfunction

    // Reference colour model written from the screen layout with the default geometry.
    function automatic logic [11:0] expColour(input logic [11:0] h, input logic [11:0] v,
                                              input logic blank, input logic [1:0] scr,
                                              input logic flash, input logic hov);
        logic ring;
        ring = ((h >= 12'd351) && (h < 12'd671) &&
                (((v >= 12'd357) && (v < 12'd367)) || ((v >= 12'd667) && (v < 12'd677)))) ||
               ((v >= 12'd357) && (v < 12'd677) &&
                (((h >= 12'd351) && (h < 12'd361)) || ((h >= 12'd661) && (h < 12'd671))));
        if (blank) return 12'h000;
        if (v == 12'd0) return 12'hff0;
        if (v == 12'd767) return 12'hf00;
        if (h == 12'd0) return 12'h0f0;
        if (h == 12'd1023) return 12'h00f;
        if (scr == 2'd0) return inButton(h, v) ? (hov ? 12'h0f0 : 12'hfff) : 12'h000;
        if (ring) begin
            if (scr == 2'd1) return 12'hfff;
            if (scr == 2'd2) return 12'h888;
            return flash ? 12'hf00 : 12'hfff;
        end
        if ((scr == 2'd2) && (h >= 12'd361) && (h < 12'd661) && (v >= 12'd367) && (v < 12'd667))
            return 12'h222;
        return 12'h000;
    endfunction

    // One pixel clock: drive, push the expectation, advance the model, pop what the DUT emits.
    task automatic applyStimulus(input logic [11:0] h, input logic [11:0] v,
                                 input logic hs, input logic vs, input logic hb, input logic vb);
        exp_t e;
        exp_t got;
        hcountIn = h; vcountIn = v; hsyncIn = hs; vsyncIn = vs; hblnkIn = hb; vblnkIn = vb;
        e.h = h; e.v = v; e.strobes = {hs, vs, hb, vb};
        e.rgb = expColour(h, v, hb | vb, mShown, mFlash, mHover);
        expQ.push_back(e);
        if (vb && !mPrevVblnk) begin
            mShown = mState;
            if (mCnt == FLASH - 1) begin
                mCnt = 0;
                mFlash = ~mFlash;
            end else begin
                mCnt++;
            end
        end
        mPrevVblnk = vb;
        mHover = inButton(xposIn, yposIn) && (mState == 2'd0);
        @(posedge pclk);
        #1;
        if (expQ.size() >= 2) begin
            e = expQ.pop_front();
            got = {hcountOut, vcountOut, {hsyncOut, vsyncOut, hblnkOut, vblnkOut}, rgbOut};
            vecCount++;
            if (got !== e) begin
                missCount++;
                $display("[TB] FAIL pipe h=%0d v=%0d: got strobes=%b rgb=%h (h=%0d v=%0d) want strobes=%b rgb=%h",
                         e.h, e.v, got.strobes, got.rgb, got.h, got.v, e.strobes, e.rgb);
            end
        end
    endtask

    task automatic idle();
        applyStimulus(12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic newFrame();
        applyStimulus(12'd0, 12'd767, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(12'd0, 12'd768, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(12'd0, 12'd769, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(12'd0, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic modelReset();
        expQ.delete();
        mState = 2'd0; mShown = 2'd0; mFlash = 1'b0; mHover = 1'b0; mPrevVblnk = 1'b0; mCnt = 0;
    endtask

    task automatic checkMode(input string name, input logic [1:0] want);
        vecCount++;
        if (modeOut !== want) begin
            missCount++;
            $display("[TB] FAIL %s: mode got %0d want %0d", name, modeOut, want);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge pclk);
        #1;
        vecCount++;
        if ({hcountOut, vcountOut, rgbOut, modeOut, hoverOut, hsyncOut, vsyncOut, hblnkOut, vblnkOut} !== '0) begin
            missCount++;
            $display("[TB] FAIL reset_hold: outputs got rgb=%h mode=%0d want all 0", rgbOut, modeOut);
        end
        rstN = 1'b1;
        gameOn = 1'b1;
        applyStimulus(12'd5, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        mState = 2'd1;
        gameOn = 1'b0;
        applyStimulus(12'd6, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(12'd7, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkMode("mode_before_reset", 2'd1);
        rstN = 1'b0;
        #1;
        vecCount++;
        if ({hcountOut, vcountOut, rgbOut, modeOut, hoverOut, hsyncOut, vsyncOut, hblnkOut, vblnkOut} !== '0) begin
            missCount++;
            $display("[TB] FAIL reset_async: got h=%0d rgb=%h mode=%0d want all 0", hcountOut, rgbOut, modeOut);
        end
        modelReset();
        repeat (2) @(posedge pclk);
        #1;
        rstN = 1'b1;
        applyStimulus(12'd5, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(12'd0, 12'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(12'd1023, 12'd100, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(12'd100, 12'd767, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(12'd200, 12'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        checkMode("mode_after_reset", 2'd0);
    endtask

    task automatic test_menu_click();
        xposIn = 12'd500; yposIn = 12'd450; mouseLeft = 1'b0;
        idle();
        vecCount++;
        if (hoverOut !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL hover_menu: got %b want 1", hoverOut);
        end
        applyStimulus(12'd500, 12'd450, 1'b0, 1'b0, 1'b0, 1'b0);
        mouseLeft = 1'b1;
        idle();
        mState = 2'd1;
        checkMode("mode_click_plus1", 2'd0);
        idle();
        checkMode("mode_click_plus2", 2'd1);
        vecCount++;
        if (hoverOut !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL hover_game: got %b want 0", hoverOut);
        end
        applyStimulus(12'd356, 12'd500, 1'b0, 1'b0, 1'b0, 1'b0);
        newFrame();
        applyStimulus(12'd356, 12'd500, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(12'd500, 12'd500, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(12'd355, 12'd360, 1'b0, 1'b0, 1'b0, 1'b0);
        mouseLeft = 1'b0;
        idle();
    endtask

    task automatic test_hold_no_click();
        menuOn = 1'b1;
        idle();
        mState = 2'd0;
        menuOn = 1'b0;
        newFrame();
        xposIn = 12'd100; yposIn = 12'd100; mouseLeft = 1'b1;
        repeat (2) idle();
        xposIn = 12'd500; yposIn = 12'd450;
        repeat (3) idle();
        checkMode("mode_held_button", 2'd0);
        applyStimulus(12'd500, 12'd450, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(12'd600, 12'd470, 1'b0, 1'b0, 1'b0, 1'b0);
        xposIn = 12'd100;
        idle();
        applyStimulus(12'd500, 12'd450, 1'b0, 1'b0, 1'b0, 1'b0);
        mouseLeft = 1'b0;
        gameOn = 1'b1;
        idle();
        mState = 2'd1;
        gameOn = 1'b0;
        idle();
        checkMode("mode_game_on", 2'd1);
    endtask

    task automatic test_over_flash();
        gameOver = 1'b1; pauseTgl = 1'b1;
        idle();
        mState = 2'd3; mCnt = 0; mFlash = 1'b0;
        gameOver = 1'b0; pauseTgl = 1'b0;
        idle();
        checkMode("mode_over", 2'd3);
        for (int f = 0; f < 5; f++) begin
            newFrame();
            applyStimulus(12'd356, 12'd500, 1'b0, 1'b0, 1'b0, 1'b0);
            applyStimulus(12'd500, 12'd360, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        mouseLeft = 1'b1;
        idle();
        mState = 2'd0;
        mouseLeft = 1'b0;
        idle();
        checkMode("mode_over_click", 2'd0);
    endtask

    task automatic test_pause();
        gameOn = 1'b1;
        idle();
        mState = 2'd1;
        gameOn = 1'b0;
        pauseTgl = 1'b1;
        idle();
        mState = 2'd2;
        pauseTgl = 1'b0;
        idle();
        checkMode("mode_pause", 2'd2);
        newFrame();
        applyStimulus(12'd500, 12'd500, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(12'd356, 12'd500, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(12'd200, 12'd200, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(12'd660, 12'd666, 1'b0, 1'b0, 1'b0, 1'b0);
        gameOver = 1'b1;
        repeat (2) idle();
        gameOver = 1'b0;
        checkMode("mode_pause_ignores_over", 2'd2);
        pauseTgl = 1'b1;
        idle();
        mState = 2'd1;
        pauseTgl = 1'b0;
        idle();
        checkMode("mode_unpause", 2'd1);
        pauseTgl = 1'b1;
        idle();
        mState = 2'd2;
        pauseTgl = 1'b0;
        menuOn = 1'b1;
        idle();
        mState = 2'd0;
        menuOn = 1'b0;
        idle();
        checkMode("mode_pause_menu", 2'd0);
    endtask

    task automatic test_random_stream();
        for (int i = 0; i < 1500; i++) begin
            xposIn = 12'($urandom_range(300, 750));
            yposIn = 12'($urandom_range(350, 520));
            applyStimulus(12'($urandom_range(0, 1023)), 12'($urandom_range(0, 767)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
        end
        repeat (2) idle();
    endtask

    initial begin
        rstN = 1'b0;
        hcountIn = '0; vcountIn = '0; hsyncIn = 1'b0; vsyncIn = 1'b0; hblnkIn = 1'b0; vblnkIn = 1'b0;
        xposIn = '0; yposIn = '0; mouseLeft = 1'b0;
        gameOn = 1'b0; menuOn = 1'b0; pauseTgl = 1'b0; gameOver = 1'b0;
        modelReset();
        test_reset();
        test_menu_click();
        test_hold_no_click();
        test_over_flash();
        test_pause();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
